// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory port between the core LSU and a UART loader.
// Optional stall cycle counter enabled by defining DMEM_ARB_STALL_CNT_EN.
`default_nettype none

module dmem_arbiter #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          MAX_WAIT = 4,
  parameter logic [2:0]  LD_RD_WR = 3'b010
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_rd_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic [2:0]        mem_rd_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_count
);

  localparam int WC_W = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {
    ST_CORE   = 2'd0,
    ST_LOADER = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_ld_ack;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              w_ld_sel;
  logic              w_grant;

  assign w_ld_sel = (r_state == ST_LOADER);
  // Idle core grants at once; busy core yields once the loader has waited MAX_WAIT-1 cycles.
  assign w_grant  = (r_state == ST_CORE) && ld_req &&
                    (!cpu_req || (r_wait_cnt == WC_W'(MAX_WAIT - 1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CORE;
      r_wait_cnt <= '0;
      r_ld_ack   <= 1'b0;
      r_ld_rdata <= '0;
    end else begin
      r_ld_ack <= 1'b0;
      case (r_state)
        ST_CORE: begin
          if (w_grant) r_state <= ST_LOADER;
        end
        ST_LOADER: begin
          r_state    <= ST_ACK;
          r_ld_ack   <= 1'b1;
          r_ld_rdata <= mem_rdata;
        end
        default: r_state <= ST_CORE;
      endcase
      if (!ld_req || w_grant) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_CORE) && cpu_req) begin
        r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end
    end
  end

  // Memory routing is combinational from state so an async reset drops a loader write at once.
  assign mem_addr  = w_ld_sel ? ld_addr  : cpu_addr;
  assign mem_wdata = w_ld_sel ? ld_wdata : cpu_wdata;
  assign mem_wr    = w_ld_sel ? ld_we    : (cpu_req & cpu_we);
  assign mem_rd_wr = w_ld_sel ? LD_RD_WR : cpu_rd_wr;
  assign cpu_stall = w_ld_sel & cpu_req;
  assign cpu_rdata = mem_rdata;
  assign ld_ack    = r_ld_ack;
  assign ld_rdata  = r_ld_rdata;

`ifdef DMEM_ARB_STALL_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= 32'h0;
    end else if (cpu_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'h0;
`endif

endmodule

`default_nettype wire
